// File: rtl/mux8_1b_rtl_if.sv
// Bus bundle for the 1-bit 8:1 mux: eight data bits, 3-bit select,
// the combinational result and its registered copy.
interface mux8_1b_rtl_if;
    logic       in0;
    logic       in1;
    logic       in2;
    logic       in3;
    logic       in4;
    logic       in5;
    logic       in6;
    logic       in7;
    logic [2:0] sel;
    logic       out;
    logic       out_q;

    modport master (
        output in0, in1, in2, in3, in4, in5, in6, in7, sel,
        input  out, out_q
    );

    modport slave (
        input  in0, in1, in2, in3, in4, in5, in6, in7, sel,
        output out, out_q
    );
endinterface

// File: rtl/mux8_1b_rtl.sv
// Single-bit 8-to-1 multiplexer with zero-latency output and a registered
// copy (out_q) that lags by one cycle; reset clears only the registered copy.
module mux8_1b_rtl (
    input  logic          clk,
    input  logic          reset,
    mux8_1b_rtl_if.slave  bus
);

    logic [7:0] data;
    logic [7:0] onehot;
    logic [7:0] gated;
    logic       out_q_reg;

    assign data = {bus.in7, bus.in6, bus.in5, bus.in4,
                   bus.in3, bus.in2, bus.in1, bus.in0};

    // One-hot decode of sel, then AND-OR reduction: exactly one lane passes.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            assign onehot[gi] = (bus.sel == 3'(gi));
            assign gated[gi]  = onehot[gi] & data[gi];
        end
    endgenerate

    assign bus.out = |gated;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q_reg <= 1'b0;
        end else begin
            out_q_reg <= bus.out;
        end
    end

    assign bus.out_q = out_q_reg;

endmodule

// File: tb/tb_mux8_1b_rtl.sv
// Directed and random checks of the 1-bit 8:1 mux and its registered copy.
module tb_mux8_1b_rtl;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    mux8_1b_rtl_if bus ();

    mux8_1b_rtl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_bit(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%b expected=%b", tag, got, exp);
        end else begin
            $display("ok   %s: got=%b", tag, got);
        end
    endtask

    task automatic apply(input logic [7:0] v, input logic [2:0] s);
        {bus.in7, bus.in6, bus.in5, bus.in4,
         bus.in3, bus.in2, bus.in1, bus.in0} = v;
        bus.sel = s;
        #1;
    endtask

    task automatic edge_then_settle;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] v;
        logic [2:0] s;
        logic       exp;
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        apply(8'h00, 3'd0);

        // Reset state of the registered copy
        edge_then_settle();
        check_bit("reset_out_q", bus.out_q, 1'b0);
        reset = 1'b0;

        // All zeros
        apply(8'h00, 3'd0); check_bit("zeros_sel0", bus.out, 1'b0);
        apply(8'h00, 3'd1); check_bit("zeros_sel1", bus.out, 1'b0);
        apply(8'h00, 3'd7); check_bit("zeros_sel7", bus.out, 1'b0);

        // Walking one, selected lane
        for (int k = 0; k < 8; k++) begin
            v = 8'h01 << k;
            apply(v, 3'(k));
            check_bit($sformatf("walk1_sel%0d", k), bus.out, 1'b1);
        end

        // Isolation: only the selected input matters
        apply(8'b1111_1110, 3'd0);
        check_bit("iso_fe_sel0", bus.out, 1'b0);
        for (int k = 1; k < 8; k++) begin
            apply(8'b0000_0001, 3'(k));
            check_bit($sformatf("iso_01_sel%0d", k), bus.out, 1'b0);
        end
        // Toggling every unselected input around a selected 1 on lane 5
        apply(8'b0010_0000, 3'd5); check_bit("iso_lane5_lo", bus.out, 1'b1);
        apply(8'b1111_1111, 3'd5); check_bit("iso_lane5_hi", bus.out, 1'b1);
        apply(8'b1101_1111, 3'd5); check_bit("iso_lane5_0", bus.out, 1'b0);

        // Random vectors: out same cycle, out_q after the next edge
        for (int i = 0; i < 24; i++) begin
            v   = 8'($urandom);
            s   = 3'($urandom_range(0, 7));
            exp = v[s];
            apply(v, s);
            check_bit($sformatf("rand%0d_v%02h_s%0d", i, v, s), bus.out, exp);
            edge_then_settle();
            check_bit($sformatf("rand%0d_q", i), bus.out_q, exp);
        end

        // Register path with reset interplay
        reset = 1'b1;
        apply(8'b0000_1000, 3'd3);
        edge_then_settle();
        check_bit("rst_held_out_q", bus.out_q, 1'b0);
        check_bit("rst_held_out", bus.out, 1'b1);
        reset = 1'b0;
        #1;
        check_bit("deassert_out", bus.out, 1'b1);
        check_bit("deassert_q_before_edge", bus.out_q, 1'b0);
        edge_then_settle();
        check_bit("deassert_q_after_edge", bus.out_q, 1'b1);
        apply(8'b0000_0000, 3'd3);
        check_bit("lag_out_now0", bus.out, 1'b0);
        check_bit("lag_q_still1", bus.out_q, 1'b1);
        edge_then_settle();
        check_bit("lag_q_now0", bus.out_q, 1'b0);
        apply(8'b0000_1000, 3'd3);
        edge_then_settle();
        check_bit("reload_q", bus.out_q, 1'b1);
        reset = 1'b1;
        edge_then_settle();
        check_bit("midop_reset_out", bus.out, 1'b1);
        check_bit("midop_reset_q", bus.out_q, 1'b0);
        reset = 1'b0;
        edge_then_settle();
        check_bit("post_reset_q", bus.out_q, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux8_1b_rtl.md
Name: mux8_1b_rtl

Overview:
Single-bit 8-to-1 multiplexer: out follows the data input selected by the 3-bit sel, with zero latency. A clock and a synchronous, active-high reset are provided. They drive only an auxiliary registered copy of the result, out_q. The block is a leaf datapath primitive used to build wider muxes and result-select logic.

Parameters:
none (fixed 1-bit data width, 8 inputs, 3-bit select)

Ports:
clk    input   1  single clock; rising-edge active
reset  input   1  synchronous, active-high reset; affects out_q only
in0    input   1  data input, selected when sel = 3'b000
in1    input   1  data input, selected when sel = 3'b001
in2    input   1  data input, selected when sel = 3'b010
in3    input   1  data input, selected when sel = 3'b011
in4    input   1  data input, selected when sel = 3'b100
in5    input   1  data input, selected when sel = 3'b101
in6    input   1  data input, selected when sel = 3'b110
in7    input   1  data input, selected when sel = 3'b111
sel    input   3  binary select, unsigned 0..7
out    output  1  combinational selected value
out_q  output  1  registered copy of out

Behaviour:
- out = in[sel] for every sel value 0..7. All 8 codes are legal and there is no default or invalid case.
- out is purely combinational:
  - zero cycles of latency;
  - settles within the same cycle that inputs change;
  - independent of clk and reset;
  - no latches and no internal state on this path.
- Structure:
  - sel is decoded into a one-hot 8-bit select, with exactly one bit high for any sel;
  - out is the OR over i of (onehot[i] AND in_i);
  - a case statement or ternary tree is equally acceptable;
  - the only functional requirement is equivalence to the truth table above.
- Unselected inputs have no effect on out; toggling any in_j with j != sel leaves out unchanged.
- out_q updates on every rising edge of clk:
  - when reset = 1 at the edge: out_q <= 0;
  - otherwise: out_q <= out.
  - out_q therefore lags out by exactly one cycle.
- Reset has no effect on out, including mid-operation. While reset is held, out still tracks in[sel].
- After reset deasserts, out_q reflects the out value sampled at the first non-reset edge.
- X-propagation:
  - if sel contains X/Z, out may be X;
  - if sel is known, out depends only on the selected input.

Test Plan:
- All zeros, sel=0 then sel=1 -> out=0 for both.
- Walking one: for each k in 0..7, drive only in_k=1 with sel=k -> out=1. Also in0=1 with sel=0 -> out=1.
- Upper-half edge cases:
  - in4=1 with sel=4 -> out=1 (likewise in5/sel=5, in6/sel=6, in7/sel=7);
  - all inputs 0 with sel=7 -> out=0.
- Isolation: inputs=8'b1111_1110 (in0=0, all others 1), sel=0 -> out=0. Then inputs=8'b0000_0001 (in0=1 only), sel=1..7 -> out=0 each.
- Random: 20+ iterations of random 8-bit input vector and random sel -> out equals vector[sel], checked within the same cycle.
- Register path:
  - assert reset for one edge -> out_q=0;
  - deassert with in3=1, sel=3 -> out=1 immediately, out_q=1 after the next rising edge;
  - assert reset while out=1 -> out stays 1, out_q=0 after the edge.
